branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the 5-stage pipeline, the successor to the static "resolve in ID, flush IF/ID" scheme. IF presents the PC and gets a taken/not-taken guess plus target in the same cycle. ID/EX returns the resolved outcome a few cycles later to train the table. It is a direct-mapped branch target buffer with N-bit saturating counters and optional gshare indexing, parametrised in depth, counter width, history length and address width.

## Interface
- `ENTRIES`, 64: number of table entries; power of two, at least 2. `IDX_W = log2(ENTRIES)`.
- `CTR_W`, 2: saturating counter width, 1..4.
- `GHR_W`, 0: global history length. 0 means plain bimodal; a value in 1..IDX_W enables gshare.
- `ADDR_W`, 32: PC width.
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `pc_i` in ADDR_W: fetch PC (word aligned).
- `pred_hit_o` out 1: lookup hit a valid entry whose tag matches.
- `pred_taken_o` out 1: predict taken.
- `pred_target_o` out ADDR_W: next fetch PC.
- `pred_ghr_o` out max(GHR_W,1): GHR snapshot used for this lookup. The pipeline carries it down to `upd_ghr_i`.
- `upd_valid_i` in 1: one resolved branch or jump this cycle.
- `upd_pc_i` in ADDR_W: PC of the resolved instruction.
- `upd_ghr_i` in max(GHR_W,1): GHR snapshot captured at its prediction.
- `upd_taken_i` in 1: actual outcome.
- `upd_target_i` in ADDR_W: actual taken target.

## Operation
- **Index**
  - Base index is `pc[IDX_W+1:2]`.
  - With GHR_W>0, the low GHR_W bits of the index are XORed with the GHR.
  - Lookup uses the live GHR; update uses `upd_ghr_i`.
- **Tag:** `pc[ADDR_W-1:IDX_W+2]`.
- **Entry contents:** valid, tag, target, counter.
- **Lookup (combinational from registered state)**
  - hit = valid & tag match.
  - taken = hit & counter MSB.
  - target = entry target if taken, else `pc_i+4` (mod 2^ADDR_W).
- **Update (rising edge while `upd_valid_i`=1)**
  - Hit, taken: counter saturating +1 (stays at 2^CTR_W−1); target is overwritten with `upd_target_i`.
  - Hit, not taken: counter saturating −1 (stays at 0); target unchanged.
  - Miss, taken: allocate, overwriting any previous occupant. Set valid=1, write tag and target, counter = 2^(CTR_W−1) (weakly taken).
  - Miss, not taken: no change to the table.
  - GHR (if GHR_W>0) becomes `{upd_ghr_i[GHR_W-2:0], upd_taken_i}`. The GHR is repaired from the snapshot, so mispredicted speculative history never persists.
- **Reset:** every entry gets valid=0, target=0, counter = 2^(CTR_W−1)−1 (weakly not-taken); GHR=0.

## Timing
- Lookup has zero-cycle latency: outputs settle combinationally from `pc_i` and state.
- An update becomes visible to lookups on the cycle after its edge.
- Lookup and update to the same entry in one cycle: the lookup sees pre-update contents (read-before-write).
- `upd_valid_i`=0 means no state change, including no GHR shift.
- Reset priority: `rst_i`=0 at an edge overrides a simultaneous update.
- Reset mid-training: after the reset edge every lookup misses and returns `pred_target_o = pc_i+4`.
- Output values while reset is held: `pred_hit_o`=0, `pred_taken_o`=0, `pred_target_o`=`pc_i+4`, `pred_ghr_o`=0.
- Aliasing: two PCs that map to the same index but carry different tags evict each other only on a taken miss.

## Structure
- Package `bp_pkg` holds:
  - counter reset constants `CTR_WNT`/`CTR_WT` as functions of CTR_W;
  - functions `sat_inc`/`sat_dec`;
  - the entry struct typedef (valid, tag, target, ctr);
  - the index/tag extraction functions.
- One natural sub-module, `bp_entry`: a single entry register with its update logic, generated ENTRIES times. The top level keeps indexing, the read mux and the GHR.

## Test plan
All scenarios use ENTRIES=16, CTR_W=2, GHR_W=0, so pc 0x40 gives index 0, tag 1.
- **Reset:** after reset, pc 0x40 → hit=0, taken=0, target=0x44.
- **Allocate:** update {pc 0x40, taken, target 0x100} → next cycle hit=1, taken=1, target=0x100, counter=2.
- **Saturation:** 3 taken updates → counter 3. Then one not-taken → counter 2, still predicts taken. A second not-taken → counter 1, taken=0, target=0x44.
- **Alias eviction:** pc 0x440 (index 0, tag 0x11) not-taken miss → 0x40 entry untouched. A taken miss at 0x440 → 0x40 now misses.
- **Simultaneous events and reset**
  - Lookup 0x40 in the same cycle as its allocating update → that cycle reports a miss; the following cycle reports a hit.
  - `rst_i`=0 with a concurrent `upd_valid_i` → table cleared.
- **Gshare (GHR_W=4):** alternating T/N branch at 0x40 with snapshots fed back → after warm-up, prediction accuracy is 100%. `pred_ghr_o` tracks the last 4 outcomes.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and helpers for branch_predictor
//
// Purpose: counter reset constants, saturating counter arithmetic, the
//          table entry record and PC index/tag extraction. Entry fields
//          are sized for the widest supported configuration; each
//          instance fills only its low bits and leaves the rest at zero.
// Ports:   none (package)
package bp_pkg;

  localparam int BP_MAX_W   = 64;  // widest supported PC / tag / target
  localparam int BP_MAX_CTR = 4;   // widest supported counter

  typedef struct packed {
    logic                  valid;
    logic [BP_MAX_W-1:0]   tag;
    logic [BP_MAX_W-1:0]   target;
    logic [BP_MAX_CTR-1:0] ctr;
  } bp_entry_t;

  // Weakly not-taken: just below the taken threshold.
  function automatic logic [BP_MAX_CTR-1:0] CTR_WNT(input int ctr_w);
    return BP_MAX_CTR'((1 << (ctr_w - 1)) - 1);
  endfunction

  // Weakly taken: the smallest value whose MSB is set.
  function automatic logic [BP_MAX_CTR-1:0] CTR_WT(input int ctr_w);
    return BP_MAX_CTR'(1 << (ctr_w - 1));
  endfunction

  function automatic logic [BP_MAX_CTR-1:0] sat_inc(input logic [BP_MAX_CTR-1:0] c,
                                                     input int ctr_w);
    logic [BP_MAX_CTR-1:0] max_v;
    max_v = BP_MAX_CTR'((1 << ctr_w) - 1);
    return (c >= max_v) ? c : c + 1'b1;
  endfunction

  function automatic logic [BP_MAX_CTR-1:0] sat_dec(input logic [BP_MAX_CTR-1:0] c,
                                                     input int ctr_w);
    if (ctr_w < 1) return c;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Word-aligned PC: bits [idx_w+1:2] select the entry.
  function automatic logic [BP_MAX_W-1:0] bp_idx(input logic [BP_MAX_W-1:0] pc,
                                                  input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Everything above the index bits is the tag.
  function automatic logic [BP_MAX_W-1:0] bp_tag(input logic [BP_MAX_W-1:0] pc,
                                                  input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_entry.sv
// rtl/bp_entry.sv - one predictor table entry with its training logic
//
// Purpose: holds valid/tag/target/counter for one slot and applies a
//          resolved-branch update when selected.
// Ports:   i_clk      clock
//          i_rst_n    synchronous active-low reset
//          i_we       update selects this entry this cycle
//          i_tag      tag of the resolved PC
//          i_taken    resolved outcome
//          i_target   resolved taken target
//          o_ent      current contents, zero-extended to package widths
module bp_entry
  import bp_pkg::*;
#(
  parameter int TAG_W  = 26,
  parameter int ADDR_W = 32,
  parameter int CTR_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_taken,
  input  logic [ADDR_W-1:0] i_target,
  output bp_entry_t         o_ent
);

  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [ADDR_W-1:0] r_target;
  logic [CTR_W-1:0]  r_ctr;
  logic              w_hit;

  assign w_hit = r_valid && (r_tag == i_tag);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= CTR_W'(CTR_WNT(CTR_W));
    end else if (i_we) begin
      if (w_hit) begin
        if (i_taken) begin
          r_ctr    <= CTR_W'(sat_inc(BP_MAX_CTR'(r_ctr), CTR_W));
          r_target <= i_target;
        end else begin
          r_ctr    <= CTR_W'(sat_dec(BP_MAX_CTR'(r_ctr), CTR_W));
        end
      end else if (i_taken) begin
        // Taken miss claims the slot; a not-taken miss leaves it alone so
        // an aliasing fall-through branch cannot evict a useful entry.
        r_valid  <= 1'b1;
        r_tag    <= i_tag;
        r_target <= i_target;
        r_ctr    <= CTR_W'(CTR_WT(CTR_W));
      end
    end
  end

  assign o_ent = '{valid:  r_valid,
                   tag:    BP_MAX_W'(r_tag),
                   target: BP_MAX_W'(r_target),
                   ctr:    BP_MAX_CTR'(r_ctr)};

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating counters and optional gshare
//
// Purpose: same-cycle taken/target prediction for IF, trained by resolved
//          branches from ID/EX. Holds indexing, the read mux and the GHR.
// Ports:   clk_i          clock
//          rst_i          synchronous active-low reset
//          pc_i           fetch PC
//          pred_hit_o     lookup hit a valid, tag-matching entry
//          pred_taken_o   predict taken
//          pred_target_o  next fetch PC
//          pred_ghr_o     GHR snapshot used by this lookup
//          upd_valid_i    a resolved branch is presented this cycle
//          upd_pc_i       its PC
//          upd_ghr_i      GHR snapshot from its prediction
//          upd_taken_i    actual outcome
//          upd_target_i   actual taken target
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CTR_W   = 2,
  parameter  int GHR_W   = 0,
  parameter  int ADDR_W  = 32,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int GW      = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic [GW-1:0]     pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [GW-1:0]     upd_ghr_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [IDX_W-1:0]  w_lk_base;
  logic [IDX_W-1:0]  w_up_base;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic [GW-1:0]     w_ghr;
  bp_entry_t         w_ents [ENTRIES];
  bp_entry_t         w_rd;
  logic              w_hit;
  logic              w_taken;
  logic [ADDR_W-1:0] w_seq;
  logic              w_unused_rd;

  assign w_lk_base = IDX_W'(bp_idx(BP_MAX_W'(pc_i), IDX_W));
  assign w_up_base = IDX_W'(bp_idx(BP_MAX_W'(upd_pc_i), IDX_W));
  assign w_up_tag  = TAG_W'(bp_tag(BP_MAX_W'(upd_pc_i), IDX_W));

  if (GHR_W > 0) begin : g_gshare
    logic [GHR_W-1:0] r_ghr;

    // History is rebuilt from the resolved branch's own snapshot, so any
    // wrong-path speculation never leaks into the live register.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        r_ghr <= '0;
      end else if (upd_valid_i) begin
        r_ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
      end
    end

    assign w_ghr    = r_ghr;
    assign w_lk_idx = w_lk_base ^ IDX_W'(r_ghr);
    assign w_up_idx = w_up_base ^ IDX_W'(upd_ghr_i);
  end else begin : g_bimodal
    logic w_unused_ghr;
    assign w_unused_ghr = ^upd_ghr_i;
    assign w_ghr        = '0;
    assign w_lk_idx     = w_lk_base;
    assign w_up_idx     = w_up_base;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bp_entry #(
      .TAG_W  (TAG_W),
      .ADDR_W (ADDR_W),
      .CTR_W  (CTR_W)
    ) u_entry (
      .i_clk    (clk_i),
      .i_rst_n  (rst_i),
      .i_we     (upd_valid_i && (w_up_idx == IDX_W'(g))),
      .i_tag    (w_up_tag),
      .i_taken  (upd_taken_i),
      .i_target (upd_target_i),
      .o_ent    (w_ents[g])
    );
  end

  // Read mux sees registered contents only, giving read-before-write when
  // lookup and update hit the same slot in one cycle.
  assign w_rd    = w_ents[w_lk_idx];
  assign w_hit   = rst_i && w_rd.valid && (w_rd.tag == bp_tag(BP_MAX_W'(pc_i), IDX_W));
  assign w_taken = w_hit && w_rd.ctr[CTR_W-1];
  assign w_seq   = pc_i + ADDR_W'(4);

  // Only the low target bits and the counter MSB feed the outputs.
  assign w_unused_rd = ^{w_rd.target, w_rd.ctr};

  assign pred_hit_o    = w_hit;
  assign pred_taken_o  = w_taken;
  assign pred_target_o = w_taken ? w_rd.target[ADDR_W-1:0] : w_seq;
  assign pred_ghr_o    = rst_i ? w_ghr : '0;

endmodule
